// File: rtl/asp_irq_ctrl.sv
// asp_irq_ctrl: N-line interrupt controller with a CSR window and a round-robin vectored req/ack arbiter.
// Optional macro ASP_IRQ_COALESCE_EN adds the COALESCE holdoff register (CSR 4) and a HOLDOFF state.
module asp_irq_ctrl #(
    parameter int NUM_IRQ_LINES = 4,
    parameter int MMIO_DATA_WIDTH = 64,
    parameter int CSR_ADDR_WIDTH = 3,
    parameter logic [NUM_IRQ_LINES-1:0] EDGE_MODE_DEFAULT = NUM_IRQ_LINES'(4'b0101),
    parameter int VEC_WIDTH = (NUM_IRQ_LINES > 1) ? $clog2(NUM_IRQ_LINES) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_IRQ_LINES-1:0]   irq_in,
    input  logic [CSR_ADDR_WIDTH-1:0]  csr_address,
    input  logic                       csr_write,
    input  logic [MMIO_DATA_WIDTH-1:0] csr_writedata,
    input  logic                       csr_read,
    output logic [MMIO_DATA_WIDTH-1:0] csr_readdata,
    output logic                       csr_readdatavalid,
    output logic                       csr_waitrequest,
    output logic                       irq_req,
    output logic [VEC_WIDTH-1:0]       irq_vec,
    input  logic                       irq_ack
);

    localparam logic [CSR_ADDR_WIDTH-1:0] A_STATUS = CSR_ADDR_WIDTH'(0);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_CLEAR  = CSR_ADDR_WIDTH'(1);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_MASK   = CSR_ADDR_WIDTH'(2);
    localparam logic [CSR_ADDR_WIDTH-1:0] A_EDGE   = CSR_ADDR_WIDTH'(3);
`ifdef ASP_IRQ_COALESCE_EN
    localparam logic [CSR_ADDR_WIDTH-1:0] A_COAL   = CSR_ADDR_WIDTH'(4);
`endif
    localparam logic [CSR_ADDR_WIDTH-1:0] A_INFO   = CSR_ADDR_WIDTH'(5);

`ifdef ASP_IRQ_COALESCE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_HOLDOFF} state_t;
`else
    typedef enum logic [0:0] {ST_IDLE, ST_REQ} state_t;
`endif

    state_t                       state_q, state_d;
    logic [NUM_IRQ_LINES-1:0]     irq_in_q;
    logic [NUM_IRQ_LINES-1:0]     pending_q, pending_d;
    logic [NUM_IRQ_LINES-1:0]     in_flight_q, in_flight_d;
    logic [NUM_IRQ_LINES-1:0]     mask_q, mask_d;
    logic [NUM_IRQ_LINES-1:0]     edge_sel_q, edge_sel_d;
    logic [VEC_WIDTH-1:0]         rr_ptr_q, rr_ptr_d;
    logic [VEC_WIDTH-1:0]         vec_q, vec_d;
    logic                         req_q, req_d;
    logic [MMIO_DATA_WIDTH-1:0]   rdata_q, rdata_d, rd_mux;
    logic                         rvalid_q;
`ifdef ASP_IRQ_COALESCE_EN
    logic [15:0]                  coal_q, coal_d;
    logic [15:0]                  cnt_q, cnt_d;
`endif

    logic [NUM_IRQ_LINES-1:0]     set_vec, clr_vec, ack_set, eligible;
    logic                         unused_wdata;

    assign unused_wdata      = ^csr_writedata;
    assign csr_waitrequest   = 1'b0;
    assign csr_readdata      = rdata_q;
    assign csr_readdatavalid = rvalid_q;
    assign irq_req           = req_q;
    assign irq_vec           = vec_q;

    function automatic logic [VEC_WIDTH-1:0] rr_pick(input logic [NUM_IRQ_LINES-1:0] elig,
                                                     input logic [VEC_WIDTH-1:0] ptr);
        logic [VEC_WIDTH-1:0] pick;
        logic                 found;
        int unsigned          idx;
        pick  = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < 32'(NUM_IRQ_LINES); k++) begin
            idx = 32'(ptr) + k;
            if (idx >= 32'(NUM_IRQ_LINES)) idx = idx - 32'(NUM_IRQ_LINES);
            if (!found && elig[idx[VEC_WIDTH-1:0]]) begin
                found = 1'b1;
                pick  = idx[VEC_WIDTH-1:0];
            end
        end
        return pick;
    endfunction

    always_comb begin
        set_vec    = (edge_sel_q & irq_in & ~irq_in_q) | (~edge_sel_q & irq_in);
        clr_vec    = (csr_write && csr_address == A_CLEAR) ? csr_writedata[NUM_IRQ_LINES-1:0] : '0;
        pending_d  = (pending_q & ~clr_vec) | set_vec;
        // in_flight follows pending down, so a cleared line can raise a fresh request
        in_flight_d = (in_flight_q | ack_set) & pending_d;
        eligible   = pending_q & ~mask_q & ~in_flight_q;
        mask_d     = (csr_write && csr_address == A_MASK) ? csr_writedata[NUM_IRQ_LINES-1:0] : mask_q;
        edge_sel_d = (csr_write && csr_address == A_EDGE) ? csr_writedata[NUM_IRQ_LINES-1:0] : edge_sel_q;
`ifdef ASP_IRQ_COALESCE_EN
        coal_d     = (csr_write && csr_address == A_COAL) ? csr_writedata[15:0] : coal_q;
`endif
    end

    always_comb begin
        rd_mux = '0;
        case (csr_address)
            A_STATUS: rd_mux[NUM_IRQ_LINES-1:0] = pending_q;
            A_MASK:   rd_mux[NUM_IRQ_LINES-1:0] = mask_q;
            A_EDGE:   rd_mux[NUM_IRQ_LINES-1:0] = edge_sel_q;
`ifdef ASP_IRQ_COALESCE_EN
            A_COAL:   rd_mux[15:0] = coal_q;
`endif
            A_INFO: begin
                rd_mux[7:0]  = 8'(NUM_IRQ_LINES);
                rd_mux[15:8] = 8'h01;
            end
            default:  rd_mux = '0;
        endcase
        rdata_d = csr_read ? rd_mux : rdata_q;
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        vec_d    = vec_q;
        rr_ptr_d = rr_ptr_q;
        ack_set  = '0;
`ifdef ASP_IRQ_COALESCE_EN
        cnt_d    = cnt_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (|eligible) begin
`ifdef ASP_IRQ_COALESCE_EN
                    if (coal_q != 16'd0) begin
                        cnt_d   = coal_q - 16'd1;
                        state_d = ST_HOLDOFF;
                    end else begin
                        vec_d   = rr_pick(eligible, rr_ptr_q);
                        req_d   = 1'b1;
                        state_d = ST_REQ;
                    end
`else
                    vec_d   = rr_pick(eligible, rr_ptr_q);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
`endif
                end
            end
            ST_REQ: begin
                if (irq_ack) begin
                    ack_set[vec_q] = 1'b1;
                    rr_ptr_d = (vec_q == VEC_WIDTH'(NUM_IRQ_LINES - 1)) ? '0 : vec_q + 1'b1;
                    req_d    = 1'b0;
                    state_d  = ST_IDLE;
                end
            end
`ifdef ASP_IRQ_COALESCE_EN
            ST_HOLDOFF: begin
                if (!(|eligible)) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    vec_d   = rr_pick(eligible, rr_ptr_q);
                    req_d   = 1'b1;
                    state_d = ST_REQ;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            irq_in_q    <= '0;
            pending_q   <= '0;
            in_flight_q <= '0;
            mask_q      <= '1;
            edge_sel_q  <= EDGE_MODE_DEFAULT;
            rr_ptr_q    <= '0;
            vec_q       <= '0;
            req_q       <= 1'b0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
`ifdef ASP_IRQ_COALESCE_EN
            coal_q      <= '0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            irq_in_q    <= irq_in;
            pending_q   <= pending_d;
            in_flight_q <= in_flight_d;
            mask_q      <= mask_d;
            edge_sel_q  <= edge_sel_d;
            rr_ptr_q    <= rr_ptr_d;
            vec_q       <= vec_d;
            req_q       <= req_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= csr_read;
`ifdef ASP_IRQ_COALESCE_EN
            coal_q      <= coal_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_asp_irq_ctrl.sv
// Self-checking bench for asp_irq_ctrl: CSR map, edge/level capture, round-robin order, masking, reset.
// Expected CSR data and request vectors go through scoreboard queues and are popped as the DUT responds.
module tb_asp_irq_ctrl;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic [2:0]  csr_address;
    logic        csr_write;
    logic [63:0] csr_writedata;
    logic        csr_read;
    logic [63:0] csr_readdata;
    logic        csr_readdatavalid;
    logic        csr_waitrequest;
    logic        irq_req;
    logic [1:0]  irq_vec;
    logic        irq_ack;

    logic [63:0] rd_exp_q[$];
    int          vec_exp_q[$];
    int          passed = 0;
    int          total  = 0;

    asp_irq_ctrl #(.NUM_IRQ_LINES(4), .MMIO_DATA_WIDTH(64), .CSR_ADDR_WIDTH(3)) dut (
        .clk(clk), .reset(reset), .irq_in(irq_in),
        .csr_address(csr_address), .csr_write(csr_write), .csr_writedata(csr_writedata),
        .csr_read(csr_read), .csr_readdata(csr_readdata), .csr_readdatavalid(csr_readdatavalid),
        .csr_waitrequest(csr_waitrequest),
        .irq_req(irq_req), .irq_vec(irq_vec), .irq_ack(irq_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [63:0] d);
        csr_address = a; csr_writedata = d; csr_write = 1'b1;
        tick();
        csr_write = 1'b0;
    endtask

    // ok is set only if readdatavalid is high exactly one cycle after the strobe and low the next
    task automatic rd(input logic [2:0] a, output logic [63:0] d, output logic ok);
        csr_address = a; csr_read = 1'b1;
        tick();
        csr_read = 1'b0;
        ok = (csr_readdatavalid === 1'b1);
        d  = csr_readdata;
        tick();
        ok = ok && (csr_readdatavalid === 1'b0);
    endtask

    task automatic wait_req(input int maxc, output logic [1:0] v, output logic ok);
        ok = 1'b0; v = '0;
        for (int i = 0; i < maxc; i++) begin
            if (irq_req === 1'b1) begin
                ok = 1'b1; v = irq_vec;
                break;
            end
            tick();
        end
    endtask

    task automatic ack_req();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        logic [2:0]  addrs [6] = '{3'd0, 3'd2, 3'd3, 3'd5, 3'd4, 3'd6};
        logic [63:0] exps  [6] = '{64'h0, 64'hF, 64'h5, 64'h104, 64'h0, 64'h0};
        logic [63:0] d, e;
        logic        ok;
        reset = 1'b1;
        repeat (2) tick();
        total++;
        if (irq_req !== 1'b0 || csr_readdatavalid !== 1'b0 || csr_waitrequest !== 1'b0)
            $display("FAIL reset_outputs: got req=%b rvalid=%b wait=%b required 0/0/0",
                     irq_req, csr_readdatavalid, csr_waitrequest);
        else passed++;
        reset = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) begin
            rd_exp_q.push_back(exps[i]);
            rd(addrs[i], d, ok);
            e = rd_exp_q.pop_front();
            total++;
            if (!ok || d !== e)
                $display("FAIL reset_read_a%0d: got %0h (valid timing ok=%b) required %0h", addrs[i], d, ok, e);
            else passed++;
        end
    endtask

    task automatic test_csr();
        logic [2:0]  addrs [4];
        logic [63:0] exps  [4];
        logic [63:0] d, e;
        logic        ok;
        wr(3'd2, 64'hFFFF_FFFF_FFFF_FFF0);
        wr(3'd3, 64'hF);
        wr(3'd0, 64'hF);
        wr(3'd5, 64'h0);
        addrs = '{3'd2, 3'd3, 3'd0, 3'd5};
        exps  = '{64'h0, 64'hF, 64'h0, 64'h104};
        for (int i = 0; i < 4; i++) begin
            rd_exp_q.push_back(exps[i]);
            rd(addrs[i], d, ok);
            e = rd_exp_q.pop_front();
            total++;
            if (!ok || d !== e)
                $display("FAIL csr_rw_a%0d: got %0h (valid timing ok=%b) required %0h", addrs[i], d, ok, e);
            else passed++;
        end
        wr(3'd3, 64'h5);
`ifndef ASP_IRQ_COALESCE_EN
        wr(3'd4, 64'hA);
        rd_exp_q.push_back(64'h0);
        rd(3'd4, d, ok);
        e = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e) $display("FAIL coalesce_absent: got %0h required %0h", d, e);
        else passed++;
`endif
    endtask

    task automatic test_edge();
        logic [63:0] d, e64;
        logic        ok, held;
        int          e;
        wr(3'd2, 64'h0);
        irq_in = 4'b0001;
        vec_exp_q.push_back(0);
        tick();
        irq_in = 4'b0000;
        total++;
        if (irq_req !== 1'b0) $display("FAIL edge_latency_early: got req=%b required 0", irq_req);
        else passed++;
        tick();
        e = vec_exp_q.pop_front();
        total++;
        if (irq_req !== 1'b1 || int'(irq_vec) != e)
            $display("FAIL edge_first_req: got req=%b vec=%0d required req=1 vec=%0d", irq_req, irq_vec, e);
        else passed++;
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (irq_req !== 1'b1 || irq_vec !== 2'd0) held = 1'b0;
        end
        total++;
        if (!held) $display("FAIL edge_hold: got req=%b vec=%0d required held req=1 vec=0", irq_req, irq_vec);
        else passed++;
        ack_req();
        held = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (irq_req !== 1'b0) held = 1'b1;
            tick();
        end
        total++;
        if (held) $display("FAIL edge_single_req: got a repeat request required none");
        else passed++;
        rd_exp_q.push_back(64'h1);
        rd(3'd0, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL edge_status: got %0h required %0h", d, e64);
        else passed++;
        wr(3'd1, 64'h1);
        rd_exp_q.push_back(64'h0);
        rd(3'd0, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL edge_w1c: got %0h required %0h", d, e64);
        else passed++;
    endtask

    task automatic test_level();
        logic [63:0] d, e64;
        logic [1:0]  v;
        logic        ok, extra;
        int          e;
        irq_in = 4'b0010;
        vec_exp_q.push_back(1);
        wait_req(10, v, ok);
        e = vec_exp_q.pop_front();
        total++;
        if (!ok || int'(v) != e) $display("FAIL level_req: got vec=%0d seen=%b required vec=%0d", v, ok, e);
        else passed++;
        ack_req();
        wr(3'd1, 64'h2);
        rd_exp_q.push_back(64'h2);
        rd(3'd0, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL level_set_wins: got %0h required %0h", d, e64);
        else passed++;
        extra = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (irq_req !== 1'b0) extra = 1'b1;
            tick();
        end
        total++;
        if (extra) $display("FAIL level_no_rereq: got a second request required none");
        else passed++;
        irq_in = 4'b0000;
        wr(3'd1, 64'h2);
        rd_exp_q.push_back(64'h0);
        rd(3'd0, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL level_clear: got %0h required %0h", d, e64);
        else passed++;
        irq_in = 4'b0010;
        vec_exp_q.push_back(1);
        wait_req(10, v, ok);
        e = vec_exp_q.pop_front();
        total++;
        if (!ok || int'(v) != e) $display("FAIL level_new_req: got vec=%0d seen=%b required vec=%0d", v, ok, e);
        else passed++;
        ack_req();
        irq_in = 4'b0000;
        wr(3'd1, 64'h2);
    endtask

    task automatic test_round_robin();
        logic [1:0] v;
        logic       ok;
        int         e;
        do_reset();
        wr(3'd2, 64'h0);
        for (int round = 0; round < 3; round++) begin
            if (round == 1) begin
                irq_in = 4'b0001;
                vec_exp_q.push_back(0);
            end else begin
                irq_in = 4'b1101;
                if (round == 0) begin
                    vec_exp_q.push_back(0); vec_exp_q.push_back(2); vec_exp_q.push_back(3);
                end else begin
                    vec_exp_q.push_back(2); vec_exp_q.push_back(3); vec_exp_q.push_back(0);
                end
            end
            tick();
            irq_in = 4'b0000;
            while (vec_exp_q.size() > 0) begin
                wait_req(10, v, ok);
                e = vec_exp_q.pop_front();
                total++;
                if (!ok || int'(v) != e)
                    $display("FAIL rr_round%0d: got vec=%0d seen=%b required vec=%0d", round, v, ok, e);
                else passed++;
                ack_req();
            end
            wr(3'd1, 64'hF);
        end
    endtask

    task automatic test_mask();
        logic [63:0] d, e64;
        logic [1:0]  v;
        logic        ok, bad;
        int          e;
        do_reset();
        wr(3'd2, 64'h4);
        irq_in = 4'b0100;
        tick();
        irq_in = 4'b0000;
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (irq_req !== 1'b0) bad = 1'b1;
            tick();
        end
        total++;
        if (bad) $display("FAIL mask_blocks: got a request required none");
        else passed++;
        rd_exp_q.push_back(64'h4);
        rd(3'd0, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL mask_status: got %0h required %0h", d, e64);
        else passed++;
        vec_exp_q.push_back(2);
        wr(3'd2, 64'h0);
        wait_req(10, v, ok);
        e = vec_exp_q.pop_front();
        total++;
        if (!ok || int'(v) != e) $display("FAIL unmask_req: got vec=%0d seen=%b required vec=%0d", v, ok, e);
        else passed++;
        wr(3'd2, 64'hF);
        bad = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (irq_req !== 1'b1 || irq_vec !== 2'd2) bad = 1'b1;
            tick();
        end
        total++;
        if (bad) $display("FAIL mask_during_req: got req=%b vec=%0d required held req=1 vec=2", irq_req, irq_vec);
        else passed++;
        ack_req();
        total++;
        if (irq_req !== 1'b0) $display("FAIL mask_ack_drop: got req=%b required 0", irq_req);
        else passed++;
        wr(3'd1, 64'hF);
        wr(3'd2, 64'h0);
        irq_in = 4'b0001;
        vec_exp_q.push_back(0);
        tick();
        irq_in = 4'b0000;
        wait_req(10, v, ok);
        e = vec_exp_q.pop_front();
        total++;
        if (!ok || int'(v) != e) $display("FAIL pre_reset_req: got vec=%0d seen=%b required vec=%0d", v, ok, e);
        else passed++;
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (irq_req !== 1'b0 || irq_vec !== 2'd0)
            $display("FAIL reset_mid_req: got req=%b vec=%0d required req=0 vec=0", irq_req, irq_vec);
        else passed++;
        tick();
        reset = 1'b0;
        tick();
        rd_exp_q.push_back(64'h0);
        rd(3'd0, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL reset_clears_pending: got %0h required %0h", d, e64);
        else passed++;
    endtask

    task automatic test_back_to_back();
        logic [2:0]  addrs [3] = '{3'd5, 3'd3, 3'd2};
        logic [63:0] e;
        int          seen;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            if (i < 3) begin
                csr_address = addrs[i];
                csr_read = 1'b1;
                case (i)
                    0: rd_exp_q.push_back(64'h104);
                    1: rd_exp_q.push_back(64'h5);
                    default: rd_exp_q.push_back(64'hF);
                endcase
            end else begin
                csr_read = 1'b0;
            end
            tick();
            if (csr_readdatavalid === 1'b1) begin
                seen++;
                e = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 64'hDEAD;
                total++;
                if (csr_readdata !== e) $display("FAIL b2b_read%0d: got %0h required %0h", i, csr_readdata, e);
                else passed++;
            end
        end
        total++;
        if (seen != 3 || csr_readdatavalid !== 1'b0)
            $display("FAIL b2b_valid_count: got %0d pulses required 3", seen);
        else passed++;
        rd_exp_q.delete();
    endtask

`ifdef ASP_IRQ_COALESCE_EN
    task automatic test_coalesce();
        logic [63:0] d, e64;
        logic [1:0]  v;
        logic        ok;
        int          e, cnt;
        do_reset();
        wr(3'd2, 64'h0);
        wr(3'd4, 64'd10);
        rd_exp_q.push_back(64'd10);
        rd(3'd4, d, ok);
        e64 = rd_exp_q.pop_front();
        total++;
        if (!ok || d !== e64) $display("FAIL coalesce_reg: got %0h required %0h", d, e64);
        else passed++;
        irq_in = 4'b0001;
        vec_exp_q.push_back(0);
        vec_exp_q.push_back(3);
        tick();
        irq_in = 4'b0000;
        cnt = 0;
        while (irq_req !== 1'b1 && cnt < 40) begin
            tick();
            cnt++;
            if (cnt == 5) irq_in = 4'b1000;
            if (cnt == 6) irq_in = 4'b0000;
        end
        e = vec_exp_q.pop_front();
        total++;
        if (irq_req !== 1'b1 || cnt != 11 || int'(irq_vec) != e)
            $display("FAIL coalesce_first: got delay=%0d vec=%0d required delay=11 vec=%0d", cnt, irq_vec, e);
        else passed++;
        ack_req();
        wait_req(30, v, ok);
        e = vec_exp_q.pop_front();
        total++;
        if (!ok || int'(v) != e) $display("FAIL coalesce_second: got vec=%0d seen=%b required vec=%0d", v, ok, e);
        else passed++;
        ack_req();
        wr(3'd1, 64'hF);
    endtask
`endif

    initial begin
        reset = 1'b1; irq_in = '0; csr_address = '0; csr_write = 1'b0;
        csr_writedata = '0; csr_read = 1'b0; irq_ack = 1'b0;
        test_reset();
        test_csr();
        test_edge();
        test_level();
        test_round_robin();
        test_mask();
        test_back_to_back();
`ifdef ASP_IRQ_COALESCE_EN
        test_coalesce();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
